// File: rtl/mul_seq_8.sv
// mul_seq_8: sequences one 32-bit operand pair through the byte-sliced
// multiplier array and carry-save combiner, buffering the result valid/ready.
`default_nettype none

module mul_seq_8 (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_sew,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic        in_last,
  output logic        cs_start,
  output logic [1:0]  cs_sew,
  output logic [63:0] mul_a,
  output logic [63:0] mul_b,
  input  logic [31:0] cs_product_1,
  input  logic [31:0] cs_product_2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_lo,
  output logic [31:0] out_hi,
  output logic        out_last,
  output logic        out_err,
  output logic        busy,
  output logic [15:0] ops_done
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    MUL1  = 3'd2,
    MUL2  = 3'd3,
    CAPT  = 3'd4
  } state_t;

  localparam logic [1:0] SEW8   = 2'b00;
  localparam logic [1:0] SEW16  = 2'b01;
  localparam logic [1:0] SEW32  = 2'b10;
  localparam logic [1:0] SEWBAD = 2'b11;

  state_t      state;
  state_t      state_nx;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [1:0]  sew_q;
  logic        last_q;
  logic        err_q;
  logic        accept;
  logic        capt_fire;
  logic        drain;

  assign accept    = (state == IDLE) && in_valid;
  assign capt_fire = (state == CAPT) && (!out_valid || out_ready);
  assign drain     = out_valid && out_ready;
  assign busy      = (state != IDLE) || out_valid;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      a_q    <= '0;
      b_q    <= '0;
      sew_q  <= SEW8;
      last_q <= 1'b0;
      err_q  <= 1'b0;
    end else if (accept) begin
      a_q    <= in_a;
      b_q    <= in_b;
      sew_q  <= in_sew;
      last_q <= in_last;
      err_q  <= (in_sew == SEWBAD);
    end
  end

  // A reload in CAPT takes priority over a same-cycle drain so the buffer stays full.
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_lo    <= '0;
      out_hi    <= '0;
      out_last  <= 1'b0;
      out_err   <= 1'b0;
    end else if (capt_fire) begin
      out_valid <= 1'b1;
      out_lo    <= err_q ? 32'd0 : cs_product_1;
      out_hi    <= err_q ? 32'd0 : cs_product_2;
      out_last  <= last_q;
      out_err   <= err_q;
    end else if (drain) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ops_done <= '0;
    end else if (drain) begin
      ops_done <= ops_done + 16'd1;
    end
  end

  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    cs_start = 1'b0;
    cs_sew   = SEW8;
    mul_a    = '0;
    mul_b    = '0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_nx = (in_sew == SEWBAD) ? CAPT : START;
        end
      end
      START: begin
        cs_start = 1'b1;
        cs_sew   = sew_q;
        state_nx = MUL1;
      end
      MUL1: begin
        // Byte i of mul_a/mul_b feeds multiplier i+1.
        case (sew_q)
          SEW8: begin
            mul_a = {32'd0, a_q};
            mul_b = {32'd0, b_q};
          end
          SEW16: begin
            mul_a = {a_q[31:16], a_q[31:16], a_q[15:0], a_q[15:0]};
            mul_b = {b_q[31:24], b_q[31:24], b_q[23:16], b_q[23:16],
                     b_q[15:8],  b_q[15:8],  b_q[7:0],   b_q[7:0]};
          end
          SEW32: begin
            mul_a = {a_q, a_q};
            mul_b = {{4{b_q[15:8]}}, {4{b_q[7:0]}}};
          end
          default: begin
            mul_a = '0;
            mul_b = '0;
          end
        endcase
        state_nx = (sew_q == SEW32) ? MUL2 : CAPT;
      end
      MUL2: begin
        mul_a    = {a_q, a_q};
        mul_b    = {{4{b_q[31:24]}}, {4{b_q[23:16]}}};
        state_nx = CAPT;
      end
      CAPT: begin
        if (capt_fire) begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: doc/mul_seq_8.md
# mul_seq_8

Sequencer for the byte-sliced multiply datapath. It sits between the vector execution issue logic and the eight 8x8 multipliers plus their carry-save combiner. It accepts one 32-bit operand pair per request at SEW 8/16/32, slices the operands into byte pairs, drives the combiner's `start`/`sew` and two-phase feeding, then captures the products into a valid/ready output buffer.

## Interface
- No parameters.
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-low reset (asserted when 0).
- `in_valid`  in  1  request valid.
- `in_ready`  out  1  request accepted when `in_valid & in_ready`.
- `in_sew`  in  2  00=8-bit, 01=16-bit, 10=32-bit, 11=illegal.
- `in_a`, `in_b`  in  32 each  unsigned operands.
- `in_last`  in  1  burst tag, passed through to `out_last`.
- `cs_start`  out  1  combiner start pulse.
- `cs_sew`  out  2  combiner mode.
- `mul_a`, `mul_b`  out  64 each  byte i (bits 8i+7:8i) feeds multiplier i+1 (`mult_out_{i+1}`).
- `cs_product_1`, `cs_product_2`  in  32 each  combiner outputs.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer ready.
- `out_lo`, `out_hi`  out  32 each  result.
- `out_last`  out  1  tag from the request.
- `out_err`  out  1  result came from an illegal-SEW request.
- `busy`  out  1  state != IDLE, or `out_valid`.
- `ops_done`  out  16  count of completed `out` handshakes; wraps at 0xFFFF->0.

## Operation
- FSM states: IDLE, START, MUL1, MUL2, CAPT.
- IDLE: `in_ready`=1. On accept, latch a, b, sew, last, then branch on SEW:
  - SEW 11: go to CAPT with the err flag set.
  - Otherwise: go to START.
- START: `cs_start`=1 and `cs_sew`=latched sew for exactly this cycle. Next state MUL1.
- MUL1: drive the phase-0 operands. If SEW 10, next state MUL2; otherwise CAPT.
- MUL2 (SEW 10 only): drive the phase-1 operands. Next state CAPT.
- CAPT:
  - If `!out_valid || out_ready`: load `out_lo`=`cs_product_1`, `out_hi`=`cs_product_2`, `out_last`, and `out_err`. Set `out_valid`. Next state IDLE.
  - Otherwise stall in CAPT. This is safe because the combiner holds its accumulators while idle.
  - Error path: `out_lo`/`out_hi` are loaded with 0 and the combiner is never started.
- Operand slicing, with a0..a3 / b0..b3 the bytes of the latched a/b (multiplier i listed as A*B):
  - SEW 00, MUL1: m1..m4 = a0*b0, a1*b1, a2*b2, a3*b3. m5..m8 = 0.
  - SEW 01, MUL1:
    - m1..m4 = a0*b0, a1*b0, a0*b1, a1*b1.
    - m5..m8 = a2*b2, a3*b2, a2*b3, a3*b3.
  - SEW 10, MUL1: m1..m4 = a0..a3 * b0; m5..m8 = a0..a3 * b1.
  - SEW 10, MUL2: m1..m4 = a0..a3 * b2; m5..m8 = a0..a3 * b3.
  - All `mul_a`/`mul_b` bytes are 0 outside MUL1/MUL2.
- Result layout:
  - SEW 00: `out_lo` = {a1*b1, a0*b0} (16 bits each); `out_hi` = {a3*b3, a2*b2}.
  - SEW 01: `out_lo` = a[15:0]*b[15:0]; `out_hi` = a[31:16]*b[31:16].
  - SEW 10: {`out_hi`, `out_lo`} = a*b (64 bits).
- Output buffer: `out_valid` clears on `out_valid & out_ready` unless CAPT reloads it in the same cycle. Simultaneous drain and reload is legal.
- `ops_done` increments on each `out_valid & out_ready`.

## Timing
- Reset (`reset`=0 at a clock edge) forces:
  - state IDLE;
  - `out_valid`, `out_err`, `out_last`, `cs_start` = 0;
  - `cs_sew`=00, `mul_a`=`mul_b`=0, `out_lo`=`out_hi`=0, `ops_done`=0.
- Reset mid-operation abandons the request: no `out_valid` follows. The combiner's reset is driven from `!reset`.
- Accept at cycle N → `cs_start` high at N+1 → combiner in PP state at N+2 (and N+3 for SEW 10).
- Products are readable in the cycle after the last PP state. CAPT is at N+3 (SEW 00/01) or N+4 (SEW 10).
- `out_valid` rises at N+4 (SEW 00/01), N+5 (SEW 10), or N+2 (illegal SEW), assuming no stall.
- `in_ready` is high only in IDLE. Best-case throughput is one request per 4 cycles (SEW 00/01) or 5 cycles (SEW 10).
- `out_lo`, `out_hi`, `out_last`, `out_err` stay stable while `out_valid & !out_ready`.

## Test plan
- SEW 00, a=0x04030201, b=0x05050505 → `out_lo`=0x000A0005, `out_hi`=0x0014000F, `out_valid` at accept+4, `cs_start` exactly one cycle.
- SEW 01, a=0x0003FFFF, b=0x00020002 → `out_lo`=0x0001FFFE, `out_hi`=0x00000006.
- SEW 10, a=0x00010000, b=0x00010000 → `out_lo`=0, `out_hi`=1, `out_valid` at accept+5. Check that the MUL1 and MUL2 `mul_b` bytes follow the phase slicing above.
- Backpressure: hold `out_ready`=0 for 10 cycles with a second request pending → first result held stable, `in_ready`=0 after the second accept until CAPT drains, second result appears after the release, `ops_done`=2.
- SEW 11 → `out_err`=1, `out_lo`=`out_hi`=0, `out_valid` at accept+2, `cs_start` never asserted.
- Drive `reset`=0 during MUL1 → next cycle state IDLE, `out_valid`=0, `ops_done`=0. After release, `in_ready`=1 and no stale result appears.
